// File: rtl/tx_seq_pkg.sv
// rtl/tx_seq_pkg.sv - state encoding, parameter defaults and widths for the TX sequencing controller
package tx_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_LOCKED = 2'd2
  } tx_state_e;

  localparam int DEF_OS_FACTOR = 4;
  localparam int DEF_LAT_MAX   = 511;
  localparam int DEF_WIN_LEN   = 64;
  localparam int DEF_LOSS_THR  = 8;
  localparam int LAT_W         = 9;

  // Next alignment latency to try; wraps to 0 past lat_max so the search never terminates.
  function automatic logic [LAT_W-1:0] lat_step(input logic [LAT_W-1:0] lat,
                                                input int unsigned     lat_max);
    if (32'(lat) >= lat_max) begin
      return '0;
    end
    return lat + LAT_W'(1);
  endfunction

endpackage

// File: rtl/tx_strobe_gen.sv
// rtl/tx_strobe_gen.sv - oversampling counter producing the symbol strobe and phase-selected downsampling strobe
module tx_strobe_gen
  import tx_seq_pkg::*;
#(
  parameter int OS_FACTOR = DEF_OS_FACTOR
) (
  input  logic       clock,
  input  logic       i_reset,
  input  logic       i_enable,
  input  logic [1:0] i_phase,
  output logic       o_sym_stb,
  output logic       o_ds_stb
);

  localparam int PH_W = (OS_FACTOR > 2) ? $clog2(OS_FACTOR) : 1;

  logic [PH_W-1:0] os_cnt_q;
  logic [PH_W-1:0] os_cnt_d;
  logic [PH_W-1:0] phase_q;
  logic [PH_W-1:0] phase_d;
  logic            sym_stb;

  assign sym_stb   = i_enable && !i_reset && (os_cnt_q == '0);
  assign o_sym_stb = sym_stb;
  assign o_ds_stb  = i_enable && !i_reset && (os_cnt_q == phase_q);

  always_comb begin
    os_cnt_d = '0;
    if (i_enable && (os_cnt_q != PH_W'(OS_FACTOR - 1))) begin
      os_cnt_d = os_cnt_q + PH_W'(1);
    end
  end

  // Out-of-range phase requests clamp to the last sample of the symbol.
  always_comb begin
    phase_d = PH_W'(i_phase);
    if ({30'd0, i_phase} >= 32'(OS_FACTOR)) begin
      phase_d = PH_W'(OS_FACTOR - 1);
    end
  end

  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      os_cnt_q <= '0;
      phase_q  <= '0;
    end else begin
      os_cnt_q <= os_cnt_d;
      if (sym_stb) begin
        phase_q <= phase_d;
      end
    end
  end

endmodule

// File: rtl/tx_seq_ctrl.sv
// rtl/tx_seq_ctrl.sv - symbol sequencer with BER alignment-latency search and lock tracking
// Optional feature: TX_SEQ_LOCK_LOSS_EN returns LOCKED to SEARCH when a window sees LOSS_THR errors.
module tx_seq_ctrl
  import tx_seq_pkg::*;
#(
  parameter int OS_FACTOR = DEF_OS_FACTOR,
  parameter int LAT_MAX   = DEF_LAT_MAX,
  parameter int WIN_LEN   = DEF_WIN_LEN,
  parameter int LOSS_THR  = DEF_LOSS_THR
) (
  input  logic             clock,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic [1:0]       i_phase,
  input  logic             i_err,
  output logic             o_sym_stb,
  output logic             o_ds_stb,
  output logic [LAT_W-1:0] o_lat_sel,
  output logic             o_locked,
  output logic [1:0]       o_state
);

  localparam int WIN_W   = (WIN_LEN > 2) ? $clog2(WIN_LEN) : 1;
  localparam int ERR_TOP = (LOSS_THR > WIN_LEN) ? LOSS_THR : WIN_LEN;
  localparam int ERR_W   = $clog2(ERR_TOP + 1);

  tx_state_e        state_q;
  logic [LAT_W-1:0] lat_q;
  logic [WIN_W-1:0] win_q;
  logic [ERR_W-1:0] err_q;
  logic [ERR_W-1:0] err_d;
  logic             locked_q;
  logic             sym_stb;
  logic             win_end;

  tx_strobe_gen #(
    .OS_FACTOR(OS_FACTOR)
  ) u_strobe (
    .clock    (clock),
    .i_reset  (i_reset),
    .i_enable (i_enable),
    .i_phase  (i_phase),
    .o_sym_stb(sym_stb),
    .o_ds_stb (o_ds_stb)
  );

  assign o_sym_stb = sym_stb;
  assign o_lat_sel = lat_q;
  assign o_locked  = locked_q;
  assign o_state   = state_q;
  assign win_end   = (win_q == WIN_W'(WIN_LEN - 1));

  // Error total including the symbol being strobed now, saturating instead of wrapping.
  always_comb begin
    err_d = err_q;
    if (i_err && (err_q != {ERR_W{1'b1}})) begin
      err_d = err_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= ST_IDLE;
      lat_q    <= '0;
      win_q    <= '0;
      err_q    <= '0;
      locked_q <= 1'b0;
    end else if (!i_enable) begin
      state_q  <= ST_IDLE;
      win_q    <= '0;
      err_q    <= '0;
      locked_q <= 1'b0;
    end else if (sym_stb) begin
      case (state_q)
        ST_IDLE: begin
          state_q  <= ST_SEARCH;
          lat_q    <= '0;
          win_q    <= '0;
          err_q    <= '0;
          locked_q <= 1'b0;
        end
        ST_SEARCH: begin
          if (win_end) begin
            win_q <= '0;
            err_q <= '0;
            if (err_d == '0) begin
              state_q  <= ST_LOCKED;
              locked_q <= 1'b1;
            end else begin
              lat_q <= lat_step(lat_q, LAT_MAX);
            end
          end else begin
            win_q <= win_q + WIN_W'(1);
            err_q <= err_d;
          end
        end
        ST_LOCKED: begin
          if (win_end) begin
            win_q <= '0;
            err_q <= '0;
`ifdef TX_SEQ_LOCK_LOSS_EN
            if (32'(err_d) >= 32'(LOSS_THR)) begin
              state_q  <= ST_SEARCH;
              locked_q <= 1'b0;
              lat_q    <= lat_step(lat_q, LAT_MAX);
            end
`endif
          end else begin
            win_q <= win_q + WIN_W'(1);
            err_q <= err_d;
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_seq_ctrl.sv
// tb/tb_tx_seq_ctrl.sv - directed bench for tx_seq_ctrl (build with/without TX_SEQ_LOCK_LOSS_EN)
module tb_tx_seq_ctrl;

  logic       clk;
  logic       rst;
  logic       en;
  logic [1:0] phase;
  logic       err;
  logic       sym;
  logic       ds;
  logic [8:0] lat;
  logic       locked;
  logic [1:0] state;

  logic       err2;
  logic       sym2;
  logic       ds2;
  logic [8:0] lat2;
  logic       locked2;
  logic [1:0] state2;

  logic       mode;
  logic       inj;
  int         k;
  int         total;
  int         bad;

  assign err  = mode ? inj : (lat != 9'd5);
  assign err2 = 1'b1;

  tx_seq_ctrl dut (
    .clock    (clk),
    .i_reset  (rst),
    .i_enable (en),
    .i_phase  (phase),
    .i_err    (err),
    .o_sym_stb(sym),
    .o_ds_stb (ds),
    .o_lat_sel(lat),
    .o_locked (locked),
    .o_state  (state)
  );

  tx_seq_ctrl #(
    .LAT_MAX(3),
    .WIN_LEN(4)
  ) dut2 (
    .clock    (clk),
    .i_reset  (rst),
    .i_enable (en),
    .i_phase  (phase),
    .i_err    (err2),
    .o_sym_stb(sym2),
    .o_ds_stb (ds2),
    .o_lat_sel(lat2),
    .o_locked (locked2),
    .o_state  (state2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s k=%0d got=%0d exp=%0d", tag, k, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
    k = k + 1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    k     = 0;
    rst   = 1'b1;
    en    = 1'b0;
    phase = 2'd0;
    mode  = 1'b0;
    inj   = 1'b0;

    #21;
    check("rst_state", state, 0);
    check("rst_lat", lat, 0);
    check("rst_locked", locked, 0);
    check("rst_sym", sym, 0);
    check("rst_ds", ds, 0);

    #19;
    rst   = 1'b0;
    en    = 1'b1;
    phase = 2'd2;
    #1;
    check("first_sym_state", state, 0);

    while (k <= 2058) begin
      if (k <= 20) begin
        check("sym_period", sym, (k % 4) == 0);
        if (k == 0) check("ds_initial", ds, 1);
        else if (k <= 12) check("ds_phase2", ds, (k % 4) == 2);
        else check("ds_phase3", ds, (k % 4) == 3);
      end
      if (k == 1) check("idle_to_search", state, 1);
      if (k == 255) check("lat_before_win1", lat, 0);
      if (k == 257) check("lat_after_win1", lat, 1);
      if (k == 1281) begin
        check("lat_reached5", lat, 5);
        check("state_search5", state, 1);
        check("unlocked5", locked, 0);
      end
      if (k == 1536) check("locked_not_yet", locked, 0);
      if (k == 1537) begin
        check("locked_win6", locked, 1);
        check("state_locked", state, 2);
        check("lat_locked", lat, 5);
      end
      if (k == 1792) check("locked_before_loss", locked, 1);
      if (k == 1793) begin
`ifdef TX_SEQ_LOCK_LOSS_EN
        check("loss_state", state, 1);
        check("loss_lat", lat, 6);
        check("loss_locked", locked, 0);
`else
        check("hold_state", state, 2);
        check("hold_lat", lat, 5);
        check("hold_locked", locked, 1);
`endif
      end
      if (k == 1801) begin
        check("dis_state", state, 0);
        check("dis_sym", sym, 0);
        check("dis_ds", ds, 0);
        check("dis_locked", locked, 0);
`ifdef TX_SEQ_LOCK_LOSS_EN
        check("dis_lat_kept", lat, 6);
`else
        check("dis_lat_kept", lat, 5);
`endif
      end
      if (k == 1802) begin
        check("reen_state", state, 1);
        check("reen_lat", lat, 0);
      end
      if (k == 2057) check("reen_lat_before", lat, 0);
      if (k == 2058) check("reen_lat_after", lat, 1);
      if (k == 16) check("lat2_before_wrap", lat2, 0);
      if (k >= 17 && k <= 129 && (k % 16) == 1) begin
        check("lat2_seq", lat2, (k / 16) % 4);
        check("lat2_unlocked", locked2, 0);
      end

      if (k == 9) phase = 2'd3;
      if (k == 1537) mode = 1'b1;
      if (k >= 1537) inj = (k >= 1540) && (k <= 1568) && ((k % 4) == 0);
      if (k == 1800) en = 1'b0;
      if (k == 1801) begin
        en   = 1'b1;
        mode = 1'b0;
        inj  = 1'b0;
      end
      step();
    end

    #2;
    rst = 1'b1;
    #1;
    check("arst_state", state, 0);
    check("arst_lat", lat, 0);
    check("arst_locked", locked, 0);
    check("arst_sym", sym, 0);
    check("arst_ds", ds, 0);
    check("arst_lat2", lat2, 0);
    check("arst_state2", state2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tx_seq_ctrl.md
TX_SEQ_CTRL -- requirements
Module: tx_seq_ctrl

Interface
REQ-001 Parameter OS_FACTOR, default 4: clocks per symbol (oversampling factor), range 2..16.
REQ-002 Parameter LAT_MAX, default 511: highest BER alignment latency tried, in symbols.
REQ-003 Parameter WIN_LEN, default 64: symbols compared per alignment trial.
REQ-004 Parameter LOSS_THR, default 8: error count per window that declares loss of lock.
REQ-005 clock  in  1  single system clock; all state updates on the rising edge.
REQ-006 i_reset  in  1  asynchronous, active-high reset.
REQ-007 i_enable  in  1  run request; low forces IDLE.
REQ-008 i_phase  in  2  downsampling phase request, 0..OS_FACTOR-1.
REQ-009 i_err  in  1  per-symbol compare result from the BER comparator; sampled only on o_sym_stb cycles.
REQ-010 o_sym_stb  out  1  one-clock symbol strobe to PRBS, filter and BER blocks.
REQ-011 o_ds_stb  out  1  one-clock downsampling strobe at the selected phase.
REQ-012 o_lat_sel  out  9  current BER alignment latency.
REQ-013 o_locked  out  1  high while in LOCKED.
REQ-014 o_state  out  2  encoded state: IDLE=0, SEARCH=1, LOCKED=2.

Function
REQ-015 os_cnt SHALL count 0..OS_FACTOR-1 and wrap while i_enable=1, and SHALL hold at 0 while i_enable=0.
REQ-016 o_sym_stb SHALL be 1 exactly when i_enable=1 and os_cnt==0.
REQ-017 o_ds_stb SHALL be 1 exactly when i_enable=1 and os_cnt==phase_q.
REQ-018 phase_q SHALL load i_phase only on o_sym_stb cycles, so a phase change takes effect at the next symbol boundary.
REQ-019 phase_q SHALL saturate to OS_FACTOR-1 when i_phase >= OS_FACTOR.
REQ-020 IDLE->SEARCH on the first o_sym_stb with i_enable=1; lat_sel, win_cnt and err_cnt SHALL be cleared on entry.
REQ-021 In SEARCH, every o_sym_stb SHALL increment win_cnt and add i_err to err_cnt.
REQ-022 At win_cnt==WIN_LEN-1: if err_cnt plus the current i_err is 0, go to LOCKED; otherwise lat_sel+1 and stay in SEARCH.
REQ-023 In both cases at the window end, win_cnt and err_cnt SHALL clear.
REQ-024 lat_sel SHALL wrap from LAT_MAX to 0 and continue searching; there is no terminal fail state.
REQ-025 In LOCKED, lat_sel SHALL be frozen; win_cnt and err_cnt SHALL keep running per REQ-021 and clear at each window end.
REQ-026 err_cnt SHALL saturate at its maximum and never wrap.
REQ-027 i_enable=0 in any state SHALL go to IDLE on the next clock and clear all counters except lat_sel.
REQ-028 i_enable=0 has priority over a simultaneous window end.
REQ-029 o_lat_sel, o_locked and o_state SHALL be registered, with 1-clock latency from the deciding strobe.

Reset
REQ-030 Asserting i_reset SHALL force, immediately, state=IDLE, all counters=0, phase_q=0, and every output=0.
REQ-031 Reset during SEARCH or LOCKED SHALL abandon the current trial with no partial window carried over.

Configuration
REQ-032 With TX_SEQ_LOCK_LOSS_EN defined: in LOCKED, a window ending with err_cnt >= LOSS_THR SHALL go to SEARCH with lat_sel+1 (wrapping) and counters cleared.
REQ-033 Without TX_SEQ_LOCK_LOSS_EN: LOCKED SHALL be left only via i_enable=0 or reset, and LOSS_THR is unused.

Structure
REQ-034 Package tx_seq_pkg SHALL hold the state encoding constants (IDLE/SEARCH/LOCKED), the default OS_FACTOR/LAT_MAX/WIN_LEN/LOSS_THR, and the lat_sel width.
REQ-035 Sub-module tx_strobe_gen SHALL contain os_cnt, phase_q, o_sym_stb and o_ds_stb.
REQ-036 tx_seq_ctrl SHALL contain the state machine and the window, error and latency counters.

Verification
REQ-037 Reset high 40 ns, then i_enable=1 with defaults: o_sym_stb every 4 clocks; o_state moves 0->1 one clock after the first strobe.
REQ-038 i_phase=2 -> o_ds_stb fires 2 clocks after each o_sym_stb. Change i_phase to 3 mid-symbol -> the new offset applies from the next o_sym_stb only.
REQ-039 Model comparator errs unless lat_sel==5 -> after 5 failed windows (5x64 symbols), o_lat_sel=5 and o_locked=1 at the end of window 6.
REQ-040 Model always errs, LAT_MAX=3 -> lat_sel sequence is 0,1,2,3,0,... and o_locked stays 0.
REQ-041 With TX_SEQ_LOCK_LOSS_EN defined, in LOCKED inject 8 errors in one window -> SEARCH with lat_sel+1. Without the macro, the same stimulus keeps o_locked=1.
REQ-042 Drop i_enable mid-window in SEARCH, or assert i_reset mid-window -> IDLE next clock (or immediately for reset), counters cleared, all strobes 0.
